cell_proc_arbiter: RTL and testbench
====================================

// Module: cell_proc_arbiter
// PURPOSE
//  Shares one CellProcessor datapath between NUM_REQ requesters (filter lanes, DMA, host).
//  Each requester presents an instruction_t with a valid/ready handshake.
//  A round-robin grant selects one instruction per cycle and drives it to the CellProcessor instance.
//  The result is registered and returned with the requester ID on a single response channel
//  that supports backpressure.
// PARAMETERS
//  NUM_REQ  4   number of requesters, 2..8
//  ID_W     $clog2(NUM_REQ)  response ID width
//  CNT_W    32  width of issue counter
// PORTS
//  clk          in   1              clock, rising edge
//  rst          in   1              reset, synchronous, active-high
//  req_valid    in   NUM_REQ        requester i has an instruction
//  req_iw       in   NUM_REQ x instruction_t  per-requester instruction
//  req_ready    out  NUM_REQ        one-hot grant; instruction i accepted this cycle
//  resp_valid   out  1              resp_result/resp_id valid
//  resp_id      out  ID_W           index of requester that issued this result
//  resp_result  out  pixel_t        CellProcessor result
//  resp_ready   in   1              consumer accepts response
//  issue_count  out  CNT_W          total accepted instructions, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset (rst=1 at clk edge):
//   - resp_valid=0, resp_id=0, resp_result=0, issue_count=0.
//   - rr_last=NUM_REQ-1, so requester 0 has top priority first.
//   - req_ready=0 while rst is high. The CellProcessor rst pin is tied to rst.
//  FSM, 2 states:
//   - EMPTY: no held response.
//   - FULL: response held with resp_valid=1.
//  can_issue = (state==EMPTY) | (state==FULL & resp_ready).
//  Grant (combinational):
//   - When can_issue, the first i with req_valid[i], searching from rr_last+1 upward modulo NUM_REQ,
//     gets req_ready[i]=1. All other req_ready bits are 0.
//   - req_ready may depend on req_valid. req_valid must not depend on req_ready.
//  Issue at a clock edge with any req_ready[i]=1:
//   - resp_result <= CellProcessor.result, with IW = req_iw[i].
//   - resp_id <= i, rr_last <= i, issue_count += 1, state -> FULL.
//  No grant, FULL, and resp_ready=1: state -> EMPTY, resp_valid -> 0.
//  FULL and resp_ready=0: hold resp_* stable and issue nothing.
//  Latency: accepted at edge N -> resp_valid visible after edge N. Throughput is 1 per cycle
//  with resp_ready held high.
//  Fairness: a continuously-valid requester is granted within NUM_REQ issue slots.
//  No req_valid: rr_last is unchanged and no IW is sampled. The IW mux drives all-zero.
//  rst mid-operation: a held response is discarded. No response is owed for it.
//  Widths: resp_result is pixel_t exactly as returned. No saturation is added here.
// STRUCTURE
//  - CellProcessingPkg gains cell_arb_state_e {ARB_EMPTY, ARB_FULL}.
//  - It also gains the function rr_pick(valid, last), which returns {found, idx}.
//  - instruction_t, pixel_t and the opcodes are reused from the package unchanged.
//  - One sub-module instance: CellProcessor u_cp, with clk, rst and IW = muxed req_iw.
//  - The arbiter, FSM and response register live in this file.
// TESTING
//  1 Reset: hold rst 3 cycles with all req_valid=1.
//    -> req_ready=0, resp_valid=0, issue_count=0 throughout.
//  2 Single request: req0 valid with a non-ADD/ADDI/SUB/SUBI opcode and center pixel 0x2A,
//    resp_ready=1.
//    -> req_ready=4'b0001 for 1 cycle, then resp_valid=1, resp_id=0, resp_result=0x2A next cycle.
//  3 Round robin: all 4 valid for 8 cycles, resp_ready=1.
//    -> grant order 0,1,2,3,0,1,2,3, and issue_count=8.
//  4 Backpressure: resp_ready=0 for 5 cycles while req1 and req2 are valid.
//    -> one response held stable and no further req_ready.
//    -> on release, one response per cycle with IDs in RR order.
//  5 Arithmetic passthrough: ADD/ADDI/SUB/SUBI with random cells from each requester.
//    -> resp_result equals the package add/addi/sub/subi model, with the matching resp_id.
//  6 Reset mid-FULL: assert rst while resp_valid=1 and resp_ready=0.
//    -> resp_valid=0 next cycle, and after release requester 0 is granted first.

Source files
------------

// File: rtl/cell_proc_arbiter_pkg.sv
// Shared types for the cell-processing slice: pixel/instruction formats, the
// arithmetic model used by the datapath, and the arbiter's state and RR picker.
package cell_proc_arbiter_pkg;

    localparam int MAX_REQ  = 8;
    localparam int RR_IDX_W = 3;

    typedef logic [7:0] pixel_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ADD  = 3'd1,
        OP_ADDI = 3'd2,
        OP_SUB  = 3'd3,
        OP_SUBI = 3'd4,
        OP_PASS = 3'd5
    } opcode_e;

    typedef struct packed {
        opcode_e op;
        pixel_t  imm;
        pixel_t  nb;
        pixel_t  center;
    } instruction_t;

    typedef enum logic [0:0] {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } cell_arb_state_e;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Pixel arithmetic wraps modulo 256.
    function automatic pixel_t cp_add(input pixel_t a, input pixel_t b);
        return a + b;
    endfunction

    function automatic pixel_t cp_addi(input pixel_t a, input pixel_t imm);
        return a + imm;
    endfunction

    function automatic pixel_t cp_sub(input pixel_t a, input pixel_t b);
        return a - b;
    endfunction

    function automatic pixel_t cp_subi(input pixel_t a, input pixel_t imm);
        return a - imm;
    endfunction

    // First set bit of valid searching from last+1 upward, wrapping at n.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [RR_IDX_W-1:0] last,
                                         input int n);
        rr_pick_t r;
        int       c;
        r = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= n && !r.found) begin
                c = int'(last) + k;
                if (c >= n) c = c - n;
                if (valid[c[RR_IDX_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = c[RR_IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cell_proc_arbiter_cp.sv
// CellProcessor datapath: one instruction in, one pixel out, combinationally,
// so the arbiter can capture the result on the same edge that accepts the instruction.
module cell_proc_arbiter_cp
    import cell_proc_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  instruction_t iw,
    output pixel_t       result
);

    always_comb begin
        result = iw.center;
        case (iw.op)
            OP_ADD:  result = cp_add(iw.center, iw.nb);
            OP_ADDI: result = cp_addi(iw.center, iw.imm);
            OP_SUB:  result = cp_sub(iw.center, iw.nb);
            OP_SUBI: result = cp_subi(iw.center, iw.imm);
            default: result = iw.center;
        endcase
    end

    // The arbiter drives all-zero when idle, so the instruction is never unknown.
    a_iw_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(iw));

endmodule

// File: rtl/cell_proc_arbiter.sv
// Round-robin arbiter sharing one CellProcessor between NUM_REQ requesters,
// with a single registered, backpressured response channel.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// req_ready[i] may depend combinationally on req_valid; req_valid never depends on
// req_ready. resp_result/resp_id are held stable while resp_valid=1 and resp_ready=0.
module cell_proc_arbiter
    import cell_proc_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  instruction_t    req_iw [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    output logic            resp_valid,
    output logic [ID_W-1:0] resp_id,
    output pixel_t          resp_result,
    input  logic            resp_ready,
    output logic [CNT_W-1:0] issue_count,
    output cell_arb_state_e dbg_state
);

    localparam logic [0:0] ST_EMPTY = 1'(ARB_EMPTY);
    localparam logic [0:0] ST_FULL  = 1'(ARB_FULL);

    logic [0:0]          state;
    logic [RR_IDX_W-1:0] rr_last;
    logic [MAX_REQ-1:0]  valid_pad;
    rr_pick_t            pick;
    logic                can_issue;
    logic                issue;
    instruction_t        iw_sel;
    pixel_t              cp_result;

    assign valid_pad = MAX_REQ'(req_valid);
    assign pick      = rr_pick(valid_pad, rr_last, NUM_REQ);

    // A held response frees its slot on the same edge it is consumed.
    assign can_issue = (state == ST_EMPTY) | resp_ready;
    assign issue     = can_issue & pick.found & ~rst;
    assign req_ready = issue ? (NUM_REQ'(1) << pick.idx) : '0;

    always_comb begin
        iw_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) iw_sel = req_iw[i];
        end
    end

    cell_proc_arbiter_cp u_cp (
        .clk    (clk),
        .rst    (rst),
        .iw     (iw_sel),
        .result (cp_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_EMPTY;
            rr_last     <= RR_IDX_W'(NUM_REQ - 1);
            resp_id     <= '0;
            resp_result <= '0;
            issue_count <= '0;
        end else if (issue) begin
            state       <= ST_FULL;
            rr_last     <= pick.idx;
            resp_id     <= pick.idx[ID_W-1:0];
            resp_result <= cp_result;
            issue_count <= issue_count + CNT_W'(1);
        end else if (state == ST_FULL && resp_ready) begin
            state <= ST_EMPTY;
        end
    end

    assign resp_valid = (state == ST_FULL);
    assign dbg_state  = cell_arb_state_e'(state);

endmodule

// File: tb/tb_cell_proc_arbiter.sv
// Directed bench for cell_proc_arbiter: inputs change on the falling edge,
// outputs are compared 1ns later, well away from the rising edge.
module tb_cell_proc_arbiter;
    import cell_proc_arbiter_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid;
    instruction_t    req_iw [4];
    logic [3:0]      req_ready;
    logic            resp_valid;
    logic [1:0]      resp_id;
    pixel_t          resp_result;
    logic            resp_ready;
    logic [31:0]     issue_count;
    cell_arb_state_e dbg_state;

    int checks = 0;
    int errors = 0;

    pixel_t     exp_q[$];
    logic [1:0] exp_id_q[$];

    always #5 clk = ~clk;

    cell_proc_arbiter #(.NUM_REQ(4), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_iw      (req_iw),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_ready  (resp_ready),
        .issue_count (issue_count),
        .dbg_state   (dbg_state)
    );

    function automatic instruction_t mk(opcode_e op, pixel_t c, pixel_t n, pixel_t imm);
        instruction_t t;
        t.op = op; t.center = c; t.nb = n; t.imm = imm;
        return t;
    endfunction

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) req_iw[i] = mk(OP_PASS, 8'(i), 8'h00, 8'h00);
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++; $display("FAIL reset_req_ready cyc%0d: got %b want 0000", c, req_ready);
            end
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++; $display("FAIL reset_resp_valid cyc%0d: got %b want 0", c, resp_valid);
            end
            checks++;
            if (issue_count !== 32'd0) begin
                errors++; $display("FAIL reset_issue_count cyc%0d: got %0d want 0", c, issue_count);
            end
        end
        checks++;
        if (resp_id !== 2'd0 || resp_result !== 8'h00 || dbg_state !== ARB_EMPTY) begin
            errors++; $display("FAIL reset_regs: id=%0d result=%h state=%0d want 0/00/0",
                               resp_id, resp_result, dbg_state);
        end
        rst = 1'b0; req_valid = 4'h0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_iw[0] = mk(OP_PASS, 8'h2A, 8'h11, 8'h22);
        req_valid = 4'b0001; resp_ready = 1'b1; #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000; #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL single_grant_once: got %b want 0000", req_ready);
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_result !== 8'h2A) begin
            errors++; $display("FAIL single_resp: valid=%b id=%0d result=%h want 1/0/2a",
                               resp_valid, resp_id, resp_result);
        end
        checks++;
        if (issue_count !== 32'd1) begin
            errors++; $display("FAIL single_count: got %0d want 1", issue_count);
        end
        @(negedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain: got %b want 0", resp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_grant;
        @(negedge clk);
        rst = 1'b1; req_valid = 4'h0;
        @(negedge clk);
        rst = 1'b0; resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) req_iw[i] = mk(OP_PASS, 8'(8'h10 + i), 8'h00, 8'h00);
        req_valid = 4'hF; #1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(negedge clk); #1;
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== 2'((k - 1) % 4) ||
                    resp_result !== 8'(8'h10 + (k - 1) % 4)) begin
                    errors++; $display("FAIL rr_resp k%0d: valid=%b id=%0d result=%h want 1/%0d/%h",
                                       k, resp_valid, resp_id, resp_result, (k - 1) % 4,
                                       8'(8'h10 + (k - 1) % 4));
                end
            end
            exp_grant = 4'b0001 << (k % 4);
            checks++;
            if (req_ready !== exp_grant) begin
                errors++; $display("FAIL rr_grant k%0d: got %b want %b", k, req_ready, exp_grant);
            end
        end
        @(negedge clk);
        req_valid = 4'h0; #1;
        checks++;
        if (resp_id !== 2'd3 || resp_result !== 8'h13) begin
            errors++; $display("FAIL rr_last_resp: id=%0d result=%h want 3/13", resp_id, resp_result);
        end
        checks++;
        if (issue_count !== 32'd8) begin
            errors++; $display("FAIL rr_count: got %0d want 8", issue_count);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req_iw[1] = mk(OP_PASS, 8'h51, 8'h00, 8'h00);
        req_iw[2] = mk(OP_PASS, 8'h62, 8'h00, 8'h00);
        req_valid = 4'b0110; resp_ready = 1'b0; #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_first_grant: got %b want 0010", req_ready);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_no_grant cyc%0d: got %b want 0000", c, req_ready);
            end
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_result !== 8'h51 ||
                issue_count !== 32'd9) begin
                errors++; $display("FAIL bp_hold cyc%0d: valid=%b id=%0d result=%h count=%0d want 1/1/51/9",
                                   c, resp_valid, resp_id, resp_result, issue_count);
            end
        end
        @(negedge clk);
        resp_ready = 1'b1; #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL bp_release_grant: got %b want 0100", req_ready);
        end
        @(negedge clk); #1;
        checks++;
        if (resp_id !== 2'd2 || resp_result !== 8'h62 || issue_count !== 32'd10) begin
            errors++; $display("FAIL bp_resp2: id=%0d result=%h count=%0d want 2/62/10",
                               resp_id, resp_result, issue_count);
        end
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_next_grant: got %b want 0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'h0; #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd1 || issue_count !== 32'd11) begin
            errors++; $display("FAIL bp_resp1: valid=%b id=%0d count=%0d want 1/1/11",
                               resp_valid, resp_id, issue_count);
        end
        @(negedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drain: got %b want 0", resp_valid);
        end
    endtask

    task automatic test_arith();
        pixel_t     c, n, imm, exp_r, got_e;
        logic [1:0] got_id;
        int         r;
        opcode_e    op;
        resp_ready = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk); #1;
            if (exp_q.size() > 0) begin
                got_e  = exp_q.pop_front();
                got_id = exp_id_q.pop_front();
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== got_id || resp_result !== got_e) begin
                    errors++; $display("FAIL arith_resp k%0d: valid=%b id=%0d result=%h want 1/%0d/%h",
                                       k, resp_valid, resp_id, resp_result, got_id, got_e);
                end
            end
            if (k == 8) begin
                req_valid = 4'h0;
            end else begin
                r = k % 4;
                if (k < 4) begin
                    // Wrap-around corners: FF+01, 80+80, 00-01, 05-06.
                    case (r)
                        0: begin c = 8'hFF; n = 8'h01; imm = 8'h00; end
                        1: begin c = 8'h80; n = 8'h00; imm = 8'h80; end
                        2: begin c = 8'h00; n = 8'h01; imm = 8'h00; end
                        default: begin c = 8'h05; n = 8'h00; imm = 8'h06; end
                    endcase
                end else begin
                    c = 8'($urandom_range(0, 255)); n = 8'($urandom_range(0, 255));
                    imm = 8'($urandom_range(0, 255));
                end
                case (r)
                    0: begin op = OP_ADD;  exp_r = 8'((int'(c) + int'(n)) % 256); end
                    1: begin op = OP_ADDI; exp_r = 8'((int'(c) + int'(imm)) % 256); end
                    2: begin op = OP_SUB;  exp_r = 8'((int'(c) - int'(n) + 256) % 256); end
                    default: begin op = OP_SUBI; exp_r = 8'((int'(c) - int'(imm) + 256) % 256); end
                endcase
                req_iw[r] = mk(op, c, n, imm);
                req_valid = 4'b0001 << r; #1;
                checks++;
                if (req_ready !== req_valid) begin
                    errors++; $display("FAIL arith_grant k%0d: got %b want %b", k, req_ready, req_valid);
                end
                exp_q.push_back(exp_r);
                exp_id_q.push_back(2'(r));
            end
        end
    endtask

    task automatic test_reset_mid_full();
        @(negedge clk);
        req_iw[0] = mk(OP_PASS, 8'h77, 8'h00, 8'h00);
        req_valid = 4'b0001; resp_ready = 1'b0; #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL midrst_grant: got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'hF; #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL midrst_held: valid=%b id=%0d ready=%b want 1/0/0000",
                               resp_valid, resp_id, req_ready);
        end
        rst = 1'b1; #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL midrst_ready_in_rst: got %b want 0000", req_ready);
        end
        @(negedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || issue_count !== 32'd0) begin
            errors++; $display("FAIL midrst_cleared: valid=%b count=%0d want 0/0", resp_valid, issue_count);
        end
        rst = 1'b0; resp_ready = 1'b1; #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL midrst_first_grant: got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'h0; #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_result !== 8'h77 ||
            issue_count !== 32'd1) begin
            errors++; $display("FAIL midrst_resp: valid=%b id=%0d result=%h count=%0d want 1/0/77/1",
                               resp_valid, resp_id, resp_result, issue_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_arith();
        test_reset_mid_full();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
